// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and byte/word helpers.
package aes_pkg;

   localparam int unsigned NR        = 10;
   localparam int unsigned KEY_W     = 128;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned IDX_W     = 4;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      K_IDLE   = 2'd0,
      K_ACTIVE = 2'd1,
      K_DONE   = 2'd2
   } kstate_e;

   // GF(2^8) multiply by x, reduced by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   // Rotate a word left by one byte: {a,b,c,d} -> {b,c,d,a}.
   function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//  i_in    in   8   input byte
//  o_sub_c out  8   substituted byte
module aes_sbox (
   input  logic [7:0] i_in,
   output logic [7:0] o_sub_c
);

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign o_sub_c = SBOX[i_in];

endmodule

// File: rtl/aes_key_expander.sv
// On-the-fly AES-128 key schedule: one round key per request, forward only.
//  clk         in   1    clock
//  reset_n     in   1    asynchronous active-low reset
//  key_load    in   1    capture cipher_key and restart the schedule
//  cipher_key  in   128  initial key, w0 = [127:96]
//  req_key     in   1    advance to next round key
//  round_key   out  128  current round key
//  round_idx   out  4    index of round_key, 0..NR
//  key_valid   out  1    pulse: round_key/round_idx updated this cycle
//  key_done    out  1    level: final round key present
module aes_key_expander
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              key_load,
   input  logic [KEY_W-1:0]  cipher_key,
   input  logic              req_key,
   output logic [KEY_W-1:0]  round_key,
   output logic [IDX_W-1:0]  round_idx,
   output logic              key_valid,
   output logic              key_done
);

   kstate_e            r_state;
   logic [KEY_W-1:0]   r_round_key;
   logic [IDX_W-1:0]   r_round_idx;
   logic [7:0]         r_rcon;
   logic               r_key_valid;
   logic               r_key_done;

   logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
   logic [WORD_W-1:0]  w_rot, w_sub, w_t;
   logic [WORD_W-1:0]  w_w4, w_w5, w_w6, w_w7;
   logic [KEY_W-1:0]   w_next_key;

   // Next round key from the current one.
   assign w_w0  = r_round_key[127:96];
   assign w_w1  = r_round_key[95:64];
   assign w_w2  = r_round_key[63:32];
   assign w_w3  = r_round_key[31:0];
   assign w_rot = rot_word(w_w3);

   // SubWord: four byte lanes through the shared S-box.
   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .i_in    (w_rot[8*g +: 8]),
         .o_sub_c (w_sub[8*g +: 8])
      );
   end

   assign w_t        = w_sub ^ {r_rcon, 24'h000000};
   assign w_w4       = w_w0 ^ w_t;
   assign w_w5       = w_w4 ^ w_w1;
   assign w_w6       = w_w5 ^ w_w2;
   assign w_w7       = w_w6 ^ w_w3;
   assign w_next_key = {w_w4, w_w5, w_w6, w_w7};

   // Schedule FSM; load takes priority over advance, advance only while active.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= K_IDLE;
         r_round_key <= '0;
         r_round_idx <= '0;
         r_rcon      <= RCON_INIT;
         r_key_valid <= 1'b0;
         r_key_done  <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (key_load) begin
            r_state     <= K_ACTIVE;
            r_round_key <= cipher_key;
            r_round_idx <= '0;
            r_rcon      <= RCON_INIT;
            r_key_valid <= 1'b1;
            r_key_done  <= 1'b0;
         end else if (req_key && (r_state == K_ACTIVE)) begin
            r_round_key <= w_next_key;
            r_round_idx <= r_round_idx + IDX_W'(1);
            r_rcon      <= xtime(r_rcon);
            r_key_valid <= 1'b1;
            if (r_round_idx == IDX_W'(NR - 1)) begin
               r_key_done <= 1'b1;
               r_state    <= K_DONE;
            end
         end
      end
   end

   assign round_key = r_round_key;
   assign round_idx = r_round_idx;
   assign key_valid = r_key_valid;
   assign key_done  = r_key_done;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key expansion vectors.
module tb_aes_key_expander;

   logic         clk;
   logic         reset_n;
   logic         key_load;
   logic [127:0] cipher_key;
   logic         req_key;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         key_done;

   int n_tests;
   int n_fail;

   logic [127:0] exp_keys [0:10];
   logic [127:0] fips_key;

   aes_key_expander dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_load   (key_load),
      .cipher_key (cipher_key),
      .req_key    (req_key),
      .round_key  (round_key),
      .round_idx  (round_idx),
      .key_valid  (key_valid),
      .key_done   (key_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_tests++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [127:0] k, input int idx,
                             input logic v, input logic d);
      check({tag, ".key"},   round_key, k);
      check({tag, ".idx"},   128'(round_idx), 128'(idx));
      check({tag, ".valid"}, 128'(key_valid), 128'(v));
      check({tag, ".done"},  128'(key_done), 128'(d));
   endtask

   task automatic do_load(input logic [127:0] k);
      cipher_key = k;
      key_load   = 1'b1;
      tick();
      key_load   = 1'b0;
   endtask

   task automatic run_held(input string tag);
      do_load(fips_key);
      check_outs({tag, ".load"}, fips_key, 0, 1'b1, 1'b0);
      req_key = 1'b1;
      for (int r = 1; r <= 10; r++) begin
         tick();
         check_outs($sformatf("%s.r%0d", tag, r), exp_keys[r], r, 1'b1, (r == 10));
      end
      req_key = 1'b0;
      tick();
      check_outs({tag, ".idle"}, exp_keys[10], 10, 1'b0, 1'b1);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      fips_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      exp_keys[0]  = fips_key;
      exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset_n    = 1'b0;
      key_load   = 1'b0;
      req_key    = 1'b0;
      cipher_key = '0;
      tick();
      tick();
      check_outs("reset", 128'h0, 0, 1'b0, 1'b0);
      reset_n = 1'b1;
      tick();

      // Requests before any load are ignored.
      req_key = 1'b1;
      tick();
      tick();
      check_outs("idle_req", 128'h0, 0, 1'b0, 1'b0);
      req_key = 1'b0;

      // Back-to-back requests through the full schedule.
      run_held("held");

      // One request every third cycle.
      do_load(fips_key);
      check_outs("sp.load", fips_key, 0, 1'b1, 1'b0);
      for (int r = 1; r <= 10; r++) begin
         req_key = 1'b1;
         tick();
         req_key = 1'b0;
         check_outs($sformatf("sp.r%0d", r), exp_keys[r], r, 1'b1, (r == 10));
         tick();
         check($sformatf("sp.gap1.r%0d", r), 128'(key_valid), 128'(0));
         tick();
         check($sformatf("sp.gap2.r%0d", r), 128'(key_valid), 128'(0));
      end

      // Extra requests after the final key are ignored.
      req_key = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_outs($sformatf("post_done%0d", i), exp_keys[10], 10, 1'b0, 1'b1);
      end
      req_key = 1'b0;

      // Load and request on the same edge: load wins.
      do_load(fips_key);
      req_key = 1'b1;
      for (int r = 1; r <= 5; r++) tick();
      req_key = 1'b0;
      check_outs("pre_coll", exp_keys[5], 5, 1'b1, 1'b0);
      cipher_key = fips_key;
      key_load   = 1'b1;
      req_key    = 1'b1;
      tick();
      key_load   = 1'b0;
      check_outs("coll", fips_key, 0, 1'b1, 1'b0);
      tick();
      req_key = 1'b0;
      check_outs("coll.r1", exp_keys[1], 1, 1'b1, 1'b0);

      // Asynchronous reset mid-schedule.
      req_key = 1'b1;
      tick();
      tick();
      tick();
      req_key = 1'b0;
      check_outs("pre_rst", exp_keys[4], 4, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check_outs("async_rst", 128'h0, 0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      run_held("reload");

      // All-zero cipher key.
      do_load(128'h0);
      check_outs("zero.load", 128'h0, 0, 1'b1, 1'b0);
      req_key = 1'b1;
      tick();
      req_key = 1'b0;
      check_outs("zero.r1", 128'h62636363626363636263636362636363, 1, 1'b1, 1'b0);
      tick();
      check_outs("zero.hold", 128'h62636363626363636263636362636363, 1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
